fifo_rd_stream: RTL and testbench

- Read-side consumer of the async FIFO.
- Attaches to the FIFO's read-domain signals (empty, rdata, rinc) and converts the pop interface into a registered valid/ready stream for downstream logic.
- Holds a 2-entry output buffer (head + skid), so m_ready never combinationally reaches rinc and a full-rate stream is possible.
- Counts delivered words for debug and throughput checks.

---
 rtl/fifo_rd_stream.sv | 118 +++++++++++
 tb/tb_fifo_rd_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer for the async FIFO. Pops words from the FIFO's
// read port into a two-entry buffer (head + skid) and presents them as a
// registered valid/ready stream. The pop decision depends only on
// registered occupancy and the FIFO's empty flag, never on m_ready, so
// downstream backpressure never forms a combinational path to rinc.
// The buffer still sustains one word per clock when m_ready stays high.
// A free-running counter records completed output handshakes for debug.
module fifo_rd_stream #(
    parameter int MSB  = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            empty,
    input  logic [MSB-1:0]  rdata,
    output logic            rinc,
    output logic [MSB-1:0]  m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [1:0]      occ,
    output logic [CNTW-1:0] word_cnt
);

    // Occupancy doubles as the controller state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic            en_reg;
    logic [1:0]      occ_reg,   occ_next;
    logic [MSB-1:0]  head_reg,  head_next;
    logic [MSB-1:0]  skid_reg,  skid_next;
    logic            valid_reg, valid_next;
    logic [CNTW-1:0] cnt_reg,   cnt_next;
    logic            push;
    logic            pop;

    // Pop from the FIFO only once out of reset, when it has data and the
    // buffer has room. Deliberately independent of m_ready.
    assign rinc = en_reg & ~empty & (occ_reg != ST_TWO);

    assign push = rinc;
    assign pop  = valid_reg & m_ready;

    assign m_data   = head_reg;
    assign m_valid  = valid_reg;
    assign occ      = occ_reg;
    assign word_cnt = cnt_reg;

    // Enable rises one edge after reset release so no pop can coincide
    // with the FIFO's own reset release on the shared net.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg <= 1'b0;
        end else begin
            en_reg <= 1'b1;
        end
    end

    // Next buffer contents: head always holds the oldest word, skid only
    // ever holds the word behind it, so ordering is preserved.
    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        skid_next = skid_reg;
        case (occ_reg)
            ST_EMPTY: begin
                if (push) begin
                    head_next = rdata;
                    occ_next  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_next = rdata;
                    occ_next  = ST_ONE;
                end else if (push) begin
                    skid_next = rdata;
                    occ_next  = ST_TWO;
                end else if (pop) begin
                    occ_next  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // rinc is held low here, so only a drain can happen.
                if (pop) begin
                    head_next = skid_reg;
                    occ_next  = ST_ONE;
                end
            end
            default: begin
                occ_next = ST_EMPTY;
            end
        endcase
        valid_next = (occ_next != ST_EMPTY);
        cnt_next   = cnt_reg + CNTW'(pop);
    end

    // Buffer, valid and handshake counter registers; head keeps the last
    // delivered word when the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg   <= ST_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            occ_reg   <= occ_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue models the upstream FIFO, words are
// pushed to an expected queue when loaded and compared on delivery.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic        m_ready = 1'b0;
    logic        rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic [1:0]  occ;
    logic [15:0] word_cnt;

    logic        empty_w = 1'b1;
    logic [7:0]  rdata_w = 8'h00;
    logic        m_ready_w = 1'b0;
    logic        rinc_w;
    logic [7:0]  m_data_w;
    logic        m_valid_w;
    logic [1:0]  occ_w;
    logic [3:0]  word_cnt_w;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    int hs_w    = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    fifo_rd_stream #(.MSB(8), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata), .rinc(rinc),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .occ(occ),
        .word_cnt(word_cnt)
    );

    fifo_rd_stream #(.MSB(8), .CNTW(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .empty(empty_w), .rdata(rdata_w), .rinc(rinc_w),
        .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready_w), .occ(occ_w),
        .word_cnt(word_cnt_w)
    );

    task automatic drive_src();
        empty = (src_q.size() == 0);
        rdata = (src_q.size() == 0) ? 8'h00 : src_q[0];
    endtask

    task automatic load(input logic [7:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        drive_src();
    endtask

    // One clock: sample handshakes before the edge, update the FIFO model after.
    task automatic tick();
        logic       p;
        logic       h;
        logic       hw;
        logic [7:0] d;
        logic [7:0] junk;
        #1;
        p  = rinc;
        h  = m_valid && m_ready;
        d  = m_data;
        hw = m_valid_w && m_ready_w;
        @(posedge clk);
        #1;
        if (p) begin
            pop_cnt++;
            if (src_q.size() > 0) junk = src_q.pop_front();
        end
        if (h) got_q.push_back(d);
        if (hw) hs_w++;
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        got_q.delete();
        m_ready = 1'b0;
        empty_w = 1'b1;
        m_ready_w = 1'b0;
        drive_src();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        pop_cnt = 0;
        hs_w = 0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0;
        m_ready = 1'b0;
        load(8'hA5);
        #1;
        n_tests++; if (rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc: got %b want 0", rinc); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
        n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
        n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        tick();
        tick();
        n_tests++; if (rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc_held: got %b want 0", rinc); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (rinc !== 1'b0) begin n_fail++; $display("FAIL release_rinc: got %b want 0", rinc); end
        tick();
        n_tests++; if (rinc !== 1'b1) begin n_fail++; $display("FAIL enable_rinc: got %b want 1", rinc); end
        tick();
        n_tests++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_fail++; $display("FAIL first_word: got v=%b d=%h want v=1 d=a5", m_valid, m_data); end
        n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL first_occ: got %0d want 1", occ); end
        m_ready = 1'b1;
        tick();
        n_tests++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL reset_deliver: got %0d words want 1", got_q.size());
        end else begin
            e = exp_q.pop_front();
            if (got_q[0] !== e) begin n_fail++; $display("FAIL reset_deliver: got %h want %h", got_q[0], e); end
            got_q.delete();
        end
        n_tests++; if (m_valid !== 1'b0 || m_data !== 8'hA5) begin n_fail++; $display("FAIL hold_last: got v=%b d=%h want v=0 d=a5", m_valid, m_data); end
        n_tests++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 1", word_cnt); end
    endtask

    task automatic test_single();
        int vcnt;
        logic [7:0] e;
        do_reset();
        m_ready = 1'b1;
        load(8'h3C);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_valid) vcnt++;
        end
        n_tests++; if (pop_cnt != 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", pop_cnt); end
        n_tests++; if (vcnt != 1) begin n_fail++; $display("FAIL single_valid: got %0d cycles want 1", vcnt); end
        n_tests++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL single_data: got %0d words want 1", got_q.size());
        end else begin
            e = exp_q.pop_front();
            if (got_q[0] !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", got_q[0], e); end
        end
        n_tests++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
        n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL single_occ: got %0d want 0", occ); end
    endtask

    task automatic test_stream();
        logic v[22];
        int occ_bad;
        int first;
        int run;
        int total;
        logic [7:0] e;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) load(8'(i));
        occ_bad = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            v[i] = m_valid;
            if (m_valid && occ !== 2'd1) occ_bad++;
        end
        first = -1; run = 0; total = 0;
        for (int i = 0; i < 22; i++) begin
            if (v[i]) begin
                total++;
                if (first < 0) first = i;
                if (i == first + run) run++;
            end
        end
        n_tests++; if (total != 16 || run != 16) begin n_fail++; $display("FAIL stream_bubbles: got total=%0d run=%0d want 16/16", total, run); end
        n_tests++; if (occ_bad != 0) begin n_fail++; $display("FAIL stream_occ: got %0d cycles with occ!=1 want 0", occ_bad); end
        n_tests++; if (got_q.size() != 16) begin n_fail++; $display("FAIL stream_count: got %0d words want 16", got_q.size()); end
        for (int i = 0; i < 16 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_q[0] !== e) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, got_q[0], e); end
            got_q.delete(0);
        end
        n_tests++; if (word_cnt !== 16'd16) begin n_fail++; $display("FAIL stream_cnt: got %0d want 16", word_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'h40 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        n_tests++; if (pop_cnt != 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", pop_cnt); end
        n_tests++; if (occ !== 2'd2 || rinc !== 1'b0) begin n_fail++; $display("FAIL bp_full: got occ=%0d rinc=%b want occ=2 rinc=0", occ, rinc); end
        n_tests++; if (m_valid !== 1'b1 || m_data !== 8'h40) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=40", m_valid, m_data); end
        n_tests++; if (src_q.size() != 3) begin n_fail++; $display("FAIL bp_retained: got %0d words in fifo want 3", src_q.size()); end
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d words want 5", got_q.size()); end
        for (int i = 0; i < 5 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_q[0] !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[0], e); end
            got_q.delete(0);
        end
    endtask

    task automatic test_toggle();
        int occ_max;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) load(8'h10 + 8'(i));
        occ_max = 0;
        for (int i = 0; i < 100 && got_q.size() < 16; i++) begin
            m_ready = ~m_ready;
            tick();
            if (int'(occ) > occ_max) occ_max = int'(occ);
        end
        n_tests++; if (got_q.size() != 16) begin n_fail++; $display("FAIL toggle_count: got %0d words want 16", got_q.size()); end
        n_tests++; if (occ_max > 2) begin n_fail++; $display("FAIL toggle_occ: got max %0d want <=2", occ_max); end
        for (int i = 0; i < 16 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_q[0] !== e) begin n_fail++; $display("FAIL toggle_data[%0d]: got %h want %h", i, got_q[0], e); end
            got_q.delete(0);
        end
        n_tests++; if (word_cnt !== 16'd16) begin n_fail++; $display("FAIL toggle_cnt: got %0d want 16", word_cnt); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] e;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) load(8'h60 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        n_tests++; if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL mid_precnt: got %0d want 3", word_cnt); end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'h70 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL mid_full: got occ=%0d want 2", occ); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (m_valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL mid_clear: got v=%b occ=%0d want v=0 occ=0", m_valid, occ); end
        n_tests++; if (word_cnt !== 16'd0 || m_data !== 8'h00) begin n_fail++; $display("FAIL mid_clear2: got cnt=%0d d=%h want 0/00", word_cnt, m_data); end
        src_q.delete();
        exp_q.delete();
        got_q.delete();
        drive_src();
        tick();
        rst_n = 1'b1;
        load(8'h99);
        #1;
        n_tests++; if (rinc !== 1'b0) begin n_fail++; $display("FAIL mid_release_rinc: got %b want 0", rinc); end
        tick();
        n_tests++; if (rinc !== 1'b1) begin n_fail++; $display("FAIL mid_resume_rinc: got %b want 1", rinc); end
        tick();
        e = exp_q.pop_front();
        n_tests++; if (m_valid !== 1'b1 || m_data !== e) begin n_fail++; $display("FAIL mid_resume_data: got v=%b d=%h want v=1 d=%h", m_valid, m_data, e); end
    endtask

    task automatic test_wrap();
        do_reset();
        rdata_w = 8'h5A;
        m_ready_w = 1'b1;
        empty_w = 1'b0;
        for (int i = 0; i < 40 && hs_w < 17; i++) begin
            tick();
            if (hs_w == 16) begin
                n_tests++; if (word_cnt_w !== 4'(hs_w % 16)) begin n_fail++; $display("FAIL wrap16: got %0d want %0d", word_cnt_w, hs_w % 16); end
            end
        end
        empty_w = 1'b1;
        n_tests++; if (hs_w != 17) begin n_fail++; $display("FAIL wrap_hs: got %0d handshakes want 17", hs_w); end
        n_tests++; if (word_cnt_w !== 4'(hs_w % 16)) begin n_fail++; $display("FAIL wrap17: got %0d want %0d", word_cnt_w, hs_w % 16); end
        m_ready_w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_toggle();
        test_reset_midop();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
